// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL feedback-path blocks.
package adpll_pkg;

   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } meter_state_t;

   // Bits needed to hold a match count of 0..lock_cnt.
   function automatic int match_cnt_w(input int lock_cnt);
      return (lock_cnt < 1) ? 1 : $clog2(lock_cnt + 1);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/fb_period_meter.sv
// Measures the divided feedback clock period in clk_in cycles, with sticky overflow.
// Frequency-lock detection is built only when FB_LOCK_DET_EN is defined.
module fb_period_meter
   import adpll_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = 2,
   parameter int EXP_PERIOD  = 4,
   parameter int TOL         = 0,
   parameter int LOCK_CNT    = 8
) (
   input  logic             clk_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             fb_clk,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             overflow,
   output logic             locked
);

   meter_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             fb_edge;
   logic             meas_event;
   logic             ovf_event;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk_in),
      .rst_n(reset_n),
      .din  (fb_clk),
      .rise (fb_edge)
   );

   // An edge wins over saturation, so an all-ones count still produces a strobe.
   assign meas_event = (state == COUNT) && fb_edge;
   assign ovf_event  = (state == COUNT) && !fb_edge && (cnt == '1);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
      end else if (!enable) begin
         state        <= IDLE;
         cnt          <= '0;
         period_valid <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt   <= '0;
               state <= ARM;
            end
            ARM: begin
               if (fb_edge) begin
                  cnt   <= CNT_W'(1);
                  state <= COUNT;
               end
            end
            COUNT: begin
               if (meas_event) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  cnt          <= CNT_W'(1);
               end else if (ovf_event) begin
                  overflow <= 1'b1;
                  cnt      <= '0;
                  state    <= ARM;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef FB_LOCK_DET_EN
   localparam int MW = match_cnt_w(LOCK_CNT);

   logic [MW-1:0] match_cnt;
   logic [CNT_W:0] cnt_x;
   logic [CNT_W:0] exp_x;
   logic [CNT_W:0] diff;
   logic           in_tol;

   // Compare at edge time so match_cnt settles together with the strobe.
   always_comb begin
      cnt_x  = {1'b0, cnt};
      exp_x  = (CNT_W+1)'(EXP_PERIOD);
      diff   = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
      in_tol = (diff <= (CNT_W+1)'(TOL));
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         match_cnt <= '0;
         locked    <= 1'b0;
      end else if (!enable || ovf_event) begin
         match_cnt <= '0;
         locked    <= 1'b0;
      end else begin
         locked <= (match_cnt == MW'(LOCK_CNT));
         if (meas_event) begin
            if (!in_tol)
               match_cnt <= '0;
            else if (match_cnt != MW'(LOCK_CNT))
               match_cnt <= match_cnt + MW'(1);
         end
      end
   end
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_fb_period_meter.sv
// Directed self-checking bench for fb_period_meter; lock checks adapt to FB_LOCK_DET_EN.
`timescale 1ns/1ps
module tb_fb_period_meter;

   logic       clk_in = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       fb_clk;
   logic [3:0] period;
   logic       period_valid;
   logic       overflow;
   logic       locked;
   logic [3:0] t_period;
   logic       t_pv;
   logic       t_ovf;
   logic       t_locked;

   int tests = 0;
   int fails = 0;
   int fb_per = 0;
   bit fb_alt = 1'b0;

`ifdef FB_LOCK_DET_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   always #2 clk_in = ~clk_in;

   fb_period_meter #(
      .CNT_W(4), .SYNC_STAGES(2), .EXP_PERIOD(4), .TOL(0), .LOCK_CNT(8)
   ) dut (
      .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .fb_clk(fb_clk),
      .period(period), .period_valid(period_valid), .overflow(overflow), .locked(locked)
   );

   fb_period_meter #(
      .CNT_W(4), .SYNC_STAGES(2), .EXP_PERIOD(4), .TOL(1), .LOCK_CNT(8)
   ) dut_tol (
      .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .fb_clk(fb_clk),
      .period(t_period), .period_valid(t_pv), .overflow(t_ovf), .locked(t_locked)
   );

   // Feedback clock: rising edge every cur cycles; fb_per=0 holds it low.
   initial begin
      int ph;
      int cur;
      ph = 0;
      cur = 1;
      fb_clk = 1'b0;
      forever begin
         @(posedge clk_in);
         #1;
         if (fb_per == 0) begin
            fb_clk = 1'b0;
            ph = 0;
            cur = 1;
         end else begin
            if (ph + 1 >= cur) begin
               ph = 0;
               cur = fb_alt ? ((cur == 3) ? 5 : 3) : fb_per;
            end else begin
               ph++;
            end
            fb_clk = (ph < cur / 2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_strobe(input int budget, output bit got, output int cycles);
      got = 1'b0;
      cycles = 0;
      while (!got && cycles < budget) begin
         @(negedge clk_in);
         cycles++;
         if (period_valid) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      fb_per = 0;
      repeat (3) @(negedge clk_in);
      tests++; if (period !== 4'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period); end
      tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL reset_pv: got %b expected 0", period_valid); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
      reset_n = 1'b1;
   endtask

   task automatic test_div4();
      bit got;
      bit found;
      int cyc;
      fb_per = 4;
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         wait_strobe(30, got, cyc);
         tests++;
         if (!got) begin fails++; $display("FAIL div4_timeout: strobe %0d not seen within 30 cycles", i); return; end
         if (i == 1) begin
            tests++; if (cyc < 6) begin fails++; $display("FAIL div4_first_latency: got %0d cycles expected >= 6", cyc); end
         end
         tests++; if (period !== 4'd4) begin fails++; $display("FAIL div4_period: strobe %0d got %0d expected 4", i, period); end
         tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL div4_ovf: got %b expected 0", overflow); end
         tests++; if (locked !== (LOCK_EN && i >= 9)) begin fails++; $display("FAIL div4_lock_at_strobe: strobe %0d got %b expected %b", i, locked, LOCK_EN && i >= 9); end
         @(negedge clk_in);
         tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL div4_pv_width: got %b expected 0", period_valid); end
         tests++; if (locked !== (LOCK_EN && i >= 8)) begin fails++; $display("FAIL div4_lock_after: strobe %0d got %b expected %b", i, locked, LOCK_EN && i >= 8); end
      end
      fb_per = 5;
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         wait_strobe(30, got, cyc);
         if (!got) break;
         if (period != 4'd4) found = 1'b1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL div5_timeout: no changed period seen"); return; end
      tests++; if (period !== 4'd5) begin fails++; $display("FAIL div5_period: got %0d expected 5", period); end
      tests++; if (locked !== LOCK_EN) begin fails++; $display("FAIL div5_lock_at_strobe: got %b expected %b", locked, LOCK_EN); end
      @(negedge clk_in);
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL div5_unlock: got %b expected 0", locked); end
   endtask

   task automatic test_overflow();
      bit got;
      bit saw_pv;
      int cyc;
      logic [3:0] p0;
      fb_per = 0;
      repeat (8) @(negedge clk_in);
      p0 = period;
      got = 1'b0;
      saw_pv = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk_in);
         if (period_valid) saw_pv = 1'b1;
         if (overflow) got = 1'b1;
      end
      tests++; if (!got) begin fails++; $display("FAIL ovf_timeout: overflow not set within 40 cycles"); end
      tests++; if (saw_pv !== 1'b0) begin fails++; $display("FAIL ovf_strobe: got strobe %b expected 0", saw_pv); end
      tests++; if (period !== p0) begin fails++; $display("FAIL ovf_period_kept: got %0d expected %0d", period, p0); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL ovf_locked: got %b expected 0", locked); end
      fb_per = 4;
      wait_strobe(40, got, cyc);
      tests++; if (!got) begin fails++; $display("FAIL ovf_resume_timeout: no strobe after resume"); return; end
      tests++; if (period !== 4'd4) begin fails++; $display("FAIL ovf_resume_period: got %0d expected 4", period); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL ovf_resume_locked: got %b expected 0", locked); end
   endtask

   task automatic test_enable_drop();
      bit got;
      int cyc;
      wait_strobe(30, got, cyc);
      tests++; if (!got) begin fails++; $display("FAIL endrop_pre_timeout: no strobe"); return; end
      repeat (2) @(negedge clk_in);
      enable = 1'b0;
      @(negedge clk_in);
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL endrop_ovf: got %b expected 0", overflow); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL endrop_locked: got %b expected 0", locked); end
      tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL endrop_pv: got %b expected 0", period_valid); end
      tests++; if (period !== 4'd4) begin fails++; $display("FAIL endrop_period_kept: got %0d expected 4", period); end
      repeat (3) @(negedge clk_in);
      enable = 1'b1;
      wait_strobe(30, got, cyc);
      tests++; if (!got) begin fails++; $display("FAIL reen_timeout: no strobe after re-enable"); return; end
      tests++; if (cyc < 6) begin fails++; $display("FAIL reen_first_edge: got %0d cycles expected >= 6", cyc); end
      tests++; if (period !== 4'd4) begin fails++; $display("FAIL reen_period: got %0d expected 4", period); end
   endtask

   task automatic test_async_reset();
      bit got;
      int cyc;
      wait_strobe(30, got, cyc);
      tests++; if (!got) begin fails++; $display("FAIL arst_pre_timeout: no strobe"); return; end
      @(posedge clk_in);
      #1;
      reset_n = 1'b0;
      #0.5;
      tests++; if (period !== 4'd0) begin fails++; $display("FAIL arst_period: got %0d expected 0", period); end
      tests++; if (period_valid !== 1'b0) begin fails++; $display("FAIL arst_pv: got %b expected 0", period_valid); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL arst_ovf: got %b expected 0", overflow); end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL arst_locked: got %b expected 0", locked); end
      @(negedge clk_in);
      reset_n = 1'b1;
      wait_strobe(30, got, cyc);
      tests++; if (!got) begin fails++; $display("FAIL arst_restart_timeout: no strobe after release"); return; end
      tests++; if (cyc < 6) begin fails++; $display("FAIL arst_restart_latency: got %0d cycles expected >= 6", cyc); end
      tests++; if (period !== 4'd4) begin fails++; $display("FAIL arst_restart_period: got %0d expected 4", period); end
   endtask

   task automatic test_alt35();
      bit got;
      int cyc;
      int prev;
      enable = 1'b0;
      fb_alt = 1'b1;
      repeat (12) @(negedge clk_in);
      enable = 1'b1;
      prev = 0;
      for (int i = 1; i <= 10; i++) begin
         got = 1'b0;
         cyc = 0;
         while (!got && cyc < 30) begin
            @(negedge clk_in);
            cyc++;
            if (t_pv) got = 1'b1;
         end
         tests++;
         if (!got) begin fails++; $display("FAIL alt_timeout: strobe %0d not seen", i); return; end
         tests++; if (t_period !== 4'd3 && t_period !== 4'd5) begin fails++; $display("FAIL alt_period_set: strobe %0d got %0d expected 3 or 5", i, t_period); end
         if (i > 1) begin
            tests++; if (int'(t_period) != 8 - prev) begin fails++; $display("FAIL alt_period_alternate: strobe %0d got %0d expected %0d", i, t_period, 8 - prev); end
         end
         tests++; if (t_locked !== (LOCK_EN && i >= 9)) begin fails++; $display("FAIL alt_lock_at_strobe: strobe %0d got %b expected %b", i, t_locked, LOCK_EN && i >= 9); end
         prev = int'(t_period);
         @(negedge clk_in);
         tests++; if (t_locked !== (LOCK_EN && i >= 8)) begin fails++; $display("FAIL alt_lock_after: strobe %0d got %b expected %b", i, t_locked, LOCK_EN && i >= 8); end
      end
      tests++; if (t_ovf !== 1'b0) begin fails++; $display("FAIL alt_ovf: got %b expected 0", t_ovf); end
   endtask

   initial begin
      test_reset();
      test_div4();
      test_overflow();
      test_enable_drop();
      test_async_reset();
      test_alt35();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
